// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared-bus arbiter with one-cycle turnaround between owners.
// Define BUS_ARB_TIMEOUT_EN to force release after MAX_HOLD owned cycles when others are waiting.
module bus_arbiter #(
   parameter int CHANNELS  = 4,
   parameter int SEL_WIDTH = 2,
   parameter int MAX_HOLD  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [CHANNELS-1:0]  req,
   output logic [CHANNELS-1:0]  grant,
   output logic [SEL_WIDTH-1:0] sel,
   output logic                 busy
);

   if (CHANNELS < 2 || (1 << SEL_WIDTH) < CHANNELS || MAX_HOLD < 2) begin : g_bad_cfg
      $error("bus_arbiter: invalid parameter combination");
   end

   typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

   state_t                state, state_nxt;
   logic [SEL_WIDTH-1:0]  ptr, ptr_nxt, sel_nxt, winner;
   logic [CHANNELS-1:0]   grant_nxt;
   logic                  busy_nxt, found, owner_req, expired, release_bus;
   int                    idx;

   // Scan ptr, ptr+1, ... wrapping at CHANNELS-1 and take the first requester.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (!found && |(req & (CHANNELS'(1) << idx))) begin
            found  = 1'b1;
            winner = SEL_WIDTH'(idx);
         end
      end
   end

   assign owner_req   = |(req & grant);
   assign release_bus = (state == OWN) && (!owner_req || expired);

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   logic [CW-1:0] cnt, cnt_nxt;

   assign expired = (cnt == CW'(MAX_HOLD - 1)) && |(req & ~grant);

   always_comb begin
      cnt_nxt = cnt;
      if (state != OWN || release_bus)
         cnt_nxt = '0;
      else if (cnt != CW'(MAX_HOLD - 1))
         cnt_nxt = cnt + CW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt_nxt;
   end
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      sel_nxt   = sel;
      busy_nxt  = busy;
      case (state)
         IDLE, TURN: begin
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
            if (found) begin
               state_nxt = OWN;
               grant_nxt = CHANNELS'(1) << winner;
               sel_nxt   = winner;
               busy_nxt  = 1'b1;
            end
         end
         OWN: begin
            if (release_bus) begin
               state_nxt = TURN;
               grant_nxt = '0;
               busy_nxt  = 1'b0;
               ptr_nxt   = (sel == SEL_WIDTH'(CHANNELS - 1)) ? '0 : sel + SEL_WIDTH'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         grant <= '0;
         sel   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         grant <= grant_nxt;
         sel   <= sel_nxt;
         busy  <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed bench for bus_arbiter (4- and 3-channel instances) with a phase-level model.
module tb_bus_arbiter;
   localparam int MAX_HOLD = 8;
   localparam int S_IDLE = 0, S_OWN = 1, S_TURN = 2;

   typedef struct {
      int phase;
      int owner;
      int ptr;
      int cnt;
      int sel;
   } mstate_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req4;
   logic [2:0] req3;
   logic [3:0] grant4;
   logic [1:0] sel4;
   logic       busy4;
   logic [2:0] grant3;
   logic [1:0] sel3;
   logic       busy3;

   int      tests = 0;
   int      fails = 0;
   bit      started = 1'b0;
   mstate_t m4, m3;

   always #5 clk = ~clk;

   bus_arbiter #(.CHANNELS(4), .SEL_WIDTH(2), .MAX_HOLD(MAX_HOLD)) u4 (
      .clock(clk), .reset(reset), .req(req4), .grant(grant4), .sel(sel4), .busy(busy4));

   bus_arbiter #(.CHANNELS(3), .SEL_WIDTH(2), .MAX_HOLD(MAX_HOLD)) u3 (
      .clock(clk), .reset(reset), .req(req3), .grant(grant3), .sel(sel3), .busy(busy3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic mstate_t idle_state();
      mstate_t s;
      s.phase = S_IDLE; s.owner = 0; s.ptr = 0; s.cnt = 0; s.sel = 0;
      return s;
   endfunction

   // One clock edge of the arbitration rules, expressed on owner/pointer indices.
   function automatic mstate_t step(mstate_t s, logic [3:0] r, int nch);
      mstate_t n = s;
      int      w = -1;
      int      j;
      int      rv = int'(r);
      bit      rel;
      if (s.phase == S_OWN) begin
         rel = ((rv >> s.owner) & 1) == 0;
`ifdef BUS_ARB_TIMEOUT_EN
         if (!rel && s.cnt == MAX_HOLD - 1 && (rv & ~(1 << s.owner) & ((1 << nch) - 1)) != 0)
            rel = 1'b1;
         else if (!rel && s.cnt < MAX_HOLD - 1)
            n.cnt = s.cnt + 1;
`endif
         if (rel) begin
            n.phase = S_TURN;
            n.ptr   = (s.owner + 1) % nch;
            n.cnt   = 0;
         end
      end else begin
         for (int k = 0; k < nch; k++) begin
            j = (s.ptr + k) % nch;
            if (w < 0 && ((rv >> j) & 1) != 0) w = j;
         end
         if (w >= 0) begin
            n.phase = S_OWN; n.owner = w; n.sel = w; n.cnt = 0;
         end else begin
            n.phase = S_IDLE;
         end
      end
      return n;
   endfunction

   function automatic int exp_grant(mstate_t s);
      return (s.phase == S_OWN) ? (1 << s.owner) : 0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m4 = idle_state();
         m3 = idle_state();
         started = 1'b1;
      end else begin
         m4 = step(m4, req4, 4);
         m3 = step(m3, {1'b0, req3}, 3);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("grant4", 32'(grant4), 32'(exp_grant(m4)));
         chk("sel4", 32'(sel4), 32'(m4.sel));
         chk("busy4", 32'(busy4), 32'(m4.phase == S_OWN));
         chk("grant3", 32'(grant3), 32'(exp_grant(m3)));
         chk("sel3", 32'(sel3), 32'(m3.sel));
         chk("busy3", 32'(busy3), 32'(m3.phase == S_OWN));
         chk("onehot4", 32'($onehot0(grant4)), 32'd1);
         chk("onehot3", 32'($onehot0(grant3)), 32'd1);
         chk("sel3_range", 32'(sel3 < 2'd3), 32'd1);
      end
   end

   task automatic drive(input logic [3:0] r, input logic rst);
      reset = rst;
      req4  = r;
      req3  = r[2:0];
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b1;
      req4  = 4'b0000;
      req3  = 3'b000;
      @(posedge clk);
      #2;
      repeat (3) drive(4'b0000, 1'b0);
      chk("idle_grant", 32'(grant4), 32'h0);
      chk("idle_sel", 32'(sel4), 32'h0);
      chk("idle_busy", 32'(busy4), 32'h0);

      drive(4'b0100, 1'b0);
      chk("own2_grant", 32'(grant4), 32'h4);
      chk("own2_sel", 32'(sel4), 32'h2);
      chk("own2_busy", 32'(busy4), 32'h1);
      repeat (4) drive(4'b0100, 1'b0);
      chk("own2_held", 32'(grant4), 32'h4);
      drive(4'b0000, 1'b0);
      chk("rel2_grant", 32'(grant4), 32'h0);
      chk("rel2_sel", 32'(sel4), 32'h2);
      drive(4'b0000, 1'b0);
      chk("idle_sel_hold", 32'(sel4), 32'h2);

      drive(4'b0100, 1'b0);
      drive(4'b0100, 1'b1);
      chk("rst_own_grant", 32'(grant4), 32'h0);
      chk("rst_own_sel", 32'(sel4), 32'h0);
      chk("rst_own_busy", 32'(busy4), 32'h0);
      drive(4'b1111, 1'b0);
      chk("rst_then_all", 32'(grant4), 32'h1);

      drive(4'b1111, 1'b1);
      for (int k = 0; k < 5; k++) begin
         drive(4'b1111, 1'b0);
         chk("rr_grant", 32'(grant4), 32'h1 << (k % 4));
         chk("rr_sel", 32'(sel4), 32'(k % 4));
         drive(4'b1111, 1'b0);
         drive(4'b1111, 1'b0);
         drive(4'b1111 & ~(4'b0001 << (k % 4)), 1'b0);
         chk("rr_turn", 32'(grant4), 32'h0);
      end

      drive(4'b0000, 1'b1);
      drive(4'b0100, 1'b0);
      chk("wrap_own", 32'(grant4), 32'h4);
      chk("wrap3_own", 32'(grant3), 32'h4);
      drive(4'b0011, 1'b0);
      chk("wrap_turn", 32'(grant4), 32'h0);
      chk("wrap3_turn", 32'(grant3), 32'h0);
      drive(4'b0011, 1'b0);
      chk("wrap_grant", 32'(grant4), 32'h1);
      chk("wrap_sel", 32'(sel4), 32'h0);
      chk("wrap3_grant", 32'(grant3), 32'h1);

      drive(4'b0000, 1'b1);
      drive(4'b0010, 1'b0);
      chk("to_own", 32'(grant4), 32'h2);
      for (int i = 1; i <= 50; i++) begin
         drive((i == 1) ? 4'b0010 : 4'b1010, 1'b0);
`ifdef BUS_ARB_TIMEOUT_EN
         if (i == 7) chk("to_hold7", 32'(grant4), 32'h2);
         if (i == 8) chk("to_release", 32'(grant4), 32'h0);
         if (i == 9) begin
            chk("to_next_grant", 32'(grant4), 32'h8);
            chk("to_next_sel", 32'(sel4), 32'h3);
         end
`else
         if (i == 8 || i == 50) chk("no_to_hold", 32'(grant4), 32'h2);
`endif
      end

      drive(4'b0000, 1'b1);
      drive(4'b0010, 1'b0);
      repeat (50) drive(4'b0010, 1'b0);
      chk("solo_hold", 32'(grant4), 32'h2);
      chk("solo_busy", 32'(busy4), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
